// File: rtl/rom_scan_ctrl.sv
// Address sequencer for the 8x4 Rom: first-match search (mode 0) or maximum search (mode 1).
// Results become valid as SCAN exits; done pulses one cycle later.
module rom_scan_ctrl #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              mode,
   input  logic [DATA_W-1:0] key,
   output logic [ADDR_W-1:0] Rom_addr,
   input  logic [DATA_W-1:0] Rom_data,
   output logic              busy,
   output logic              done,
   output logic              found,
   output logic [ADDR_W-1:0] result_index,
   output logic [DATA_W-1:0] result_value
);

   // state  | meaning
   // S_IDLE | waiting for start, Rom_addr held at 0
   // S_SCAN | one Rom address evaluated per cycle
   // S_DONE | results written; done pulse issued on leaving
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              r_state,   w_state_nxt;
   logic [ADDR_W-1:0]   r_addr,    w_addr_nxt;
   logic                r_busy,    w_busy_nxt;
   logic                r_done,    w_done_nxt;
   logic                r_found,   w_found_nxt;
   logic [ADDR_W-1:0]   r_idx,     w_idx_nxt;
   logic [DATA_W-1:0]   r_val,     w_val_nxt;
   logic                r_mode,    w_mode_nxt;
   logic [DATA_W-1:0]   r_key,     w_key_nxt;
   logic [DATA_W-1:0]   r_max,     w_max_nxt;
   logic [ADDR_W-1:0]   r_max_idx, w_max_idx_nxt;
   logic                w_last;
   logic                w_take;

   assign w_last = (r_addr == {ADDR_W{1'b1}});
   // Strict greater-than keeps the lowest index on ties.
   assign w_take = (r_addr == '0) || (Rom_data > r_max);

   always_comb begin
      w_state_nxt   = r_state;
      w_addr_nxt    = r_addr;
      w_busy_nxt    = r_busy;
      w_done_nxt    = 1'b0;
      w_found_nxt   = r_found;
      w_idx_nxt     = r_idx;
      w_val_nxt     = r_val;
      w_mode_nxt    = r_mode;
      w_key_nxt     = r_key;
      w_max_nxt     = r_max;
      w_max_idx_nxt = r_max_idx;
      unique case (r_state)
         S_IDLE: begin
            w_addr_nxt = '0;
            if (start) begin
               w_mode_nxt  = mode;
               w_key_nxt   = key;
               w_busy_nxt  = 1'b1;
               w_state_nxt = S_SCAN;
            end
         end
         S_SCAN: begin
            if (!r_mode) begin
               if (Rom_data == r_key) begin
                  w_found_nxt = 1'b1;
                  w_idx_nxt   = r_addr;
                  w_val_nxt   = Rom_data;
                  w_state_nxt = S_DONE;
               end else if (w_last) begin
                  w_found_nxt = 1'b0;
                  w_idx_nxt   = '0;
                  w_val_nxt   = '0;
                  w_state_nxt = S_DONE;
               end else begin
                  w_addr_nxt  = r_addr + 1'b1;
               end
            end else begin
               if (w_take) begin
                  w_max_nxt     = Rom_data;
                  w_max_idx_nxt = r_addr;
               end
               if (w_last) begin
                  w_found_nxt = 1'b1;
                  w_idx_nxt   = w_take ? r_addr   : r_max_idx;
                  w_val_nxt   = w_take ? Rom_data : r_max;
                  w_state_nxt = S_DONE;
               end else begin
                  w_addr_nxt  = r_addr + 1'b1;
               end
            end
            if (w_state_nxt == S_DONE) begin
               w_busy_nxt = 1'b0;
               w_addr_nxt = '0;
            end
         end
         S_DONE: begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
            w_addr_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_addr    <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_found   <= 1'b0;
         r_idx     <= '0;
         r_val     <= '0;
         r_mode    <= 1'b0;
         r_key     <= '0;
         r_max     <= '0;
         r_max_idx <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_addr    <= w_addr_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
         r_found   <= w_found_nxt;
         r_idx     <= w_idx_nxt;
         r_val     <= w_val_nxt;
         r_mode    <= w_mode_nxt;
         r_key     <= w_key_nxt;
         r_max     <= w_max_nxt;
         r_max_idx <= w_max_idx_nxt;
      end
   end

   assign Rom_addr     = r_addr;
   assign busy         = r_busy;
   assign done         = r_done;
   assign found        = r_found;
   assign result_index = r_idx;
   assign result_value = r_val;

endmodule
